// File: rtl/sta_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sta_ctrl_pkg
//  Purpose  : Shared types and helpers for the systolic tensor array tile
//             sequencer: FSM state encoding, drain-length helper and the
//             default per-hop PE latency.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sta_ctrl_pkg;

  // Default number of cycles an operand takes to hop from one PE to the next.
  localparam int STA_PE_LATENCY_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5
  } sta_ctrl_state_t;

  // Cycles from the last feed beat until PE(M-1,N-1) holds its final sum:
  // the worst-case skew plus the propagation across the array diagonal.
  function automatic int drain_cycles(input int m, input int n, input int pe_latency);
    return (m + n - 1) * pe_latency;
  endfunction

endpackage : sta_ctrl_pkg
`default_nettype wire

// File: rtl/sta_skew_line.sv
`default_nettype none
// ============================================================================
//  Module   : sta_skew_line
//  Purpose  : Delay line that turns a single feed enable into a set of
//             enables staggered by PE_LATENCY cycles each. Tap 0 is the input
//             itself (no delay); tap t is the input delayed t*PE_LATENCY.
//  Ports    :
//    clk_i     in   1      clock, rising edge
//    reset_ni  in   1      asynchronous active-low clear of the line
//    in_i      in   1      enable to be skewed
//    taps_o    out  TAPS   skewed copies of in_i
//  Revision : 1.0 - initial release
// ============================================================================
module sta_skew_line #(
  parameter int TAPS       = 2,
  parameter int PE_LATENCY = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            in_i,
  output logic [TAPS-1:0] taps_o
);

  // Number of positions on the line, position 0 being the undelayed input.
  localparam int c_DEPTH = (TAPS - 1) * PE_LATENCY + 1;

  logic [c_DEPTH-1:0] w_line;

  assign w_line[0] = in_i;

  generate
    if (c_DEPTH > 1) begin : g_regs
      logic [c_DEPTH-1:1] r_sr;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          r_sr <= '0;
        end else begin
          r_sr[1] <= in_i;
          for (int i = 2; i < c_DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
          end
        end
      end

      assign w_line[c_DEPTH-1:1] = r_sr;
    end
  endgenerate

  generate
    for (genvar t = 0; t < TAPS; t++) begin : g_taps
      assign taps_o[t] = w_line[t*PE_LATENCY];
    end
  endgenerate

endmodule : sta_skew_line
`default_nettype wire

// File: rtl/sta_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sta_tile_ctrl
//  Purpose  : Job sequencer for an MxN systolic tensor array. For each job it
//             clears the accumulators, streams K operand vectors with skewed
//             per-row / per-column enables, waits for the array to drain and
//             then walks the MxN results out over a valid/ready handshake.
//  Options  : STA_TILE_CTRL_PERF_EN - adds perf_cycles_o, the number of busy
//             cycles of the current (or most recent) job.
//  Ports    :
//    clk_i          in   1           clock, rising edge
//    reset_ni       in   1           asynchronous active-low reset
//    start_i        in   1           job request, honoured only when idle
//    k_steps_i      in   K_WIDTH     reduction length, latched with start_i
//    busy_o         out  1           job in progress
//    done_o         out  1           one-cycle end-of-job pulse
//    acc_clear_o    out  1           accumulator clear pulse
//    feed_en_o      out  1           operand buffer read enable
//    feed_addr_o    out  ADDR_WIDTH  operand buffer read address
//    data_en_o      out  N           per-column skewed data enable
//    weight_en_o    out  M           per-row skewed weight enable
//    res_valid_o    out  1           result select valid
//    res_ready_i    in   1           consumer accepts result
//    res_row_o      out  clog2(M)    result row index
//    res_col_o      out  clog2(N)    result column index
//    perf_cycles_o  out  32          busy cycle count (option only)
//  Revision : 1.0 - initial release
// ============================================================================
module sta_tile_ctrl
  import sta_ctrl_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int PE_LATENCY = STA_PE_LATENCY_DEFAULT,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 start_i,
  input  logic [K_WIDTH-1:0]                   k_steps_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 acc_clear_o,
  output logic                                 feed_en_o,
  output logic [ADDR_WIDTH-1:0]                feed_addr_o,
  output logic [N-1:0]                         data_en_o,
  output logic [M-1:0]                         weight_en_o,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] res_row_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] res_col_o
`ifdef STA_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                          perf_cycles_o
`endif
);

  localparam int c_ROW_W        = (M > 1) ? $clog2(M) : 1;
  localparam int c_COL_W        = (N > 1) ? $clog2(N) : 1;
  localparam int c_DRAIN_CYCLES = drain_cycles(M, N, PE_LATENCY);
  localparam int c_DRAIN_W      = $clog2(c_DRAIN_CYCLES + 1);
  // One counter serves both FEED and DRAIN, so it must fit either range.
  localparam int c_CNT_W        = (K_WIDTH > c_DRAIN_W) ? K_WIDTH : c_DRAIN_W;
  localparam int c_TAPS         = (M > N) ? M : N;

  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(c_DRAIN_CYCLES - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST   = c_ROW_W'(M - 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST   = c_COL_W'(N - 1);

  sta_ctrl_state_t     r_state, w_nxt_state;
  logic [c_CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [K_WIDTH-1:0]  r_k, w_nxt_k;
  logic [c_ROW_W-1:0]  r_row, w_nxt_row;
  logic [c_COL_W-1:0]  r_col, w_nxt_col;
  logic                w_accept;
  logic [c_CNT_W-1:0]  w_k_last;

  logic                r_busy;
  logic                r_done;
  logic                r_acc_clear;
  logic                r_feed_en;
  logic [ADDR_WIDTH-1:0] r_feed_addr;
  logic                r_res_valid;
  logic [c_TAPS-1:0]   w_taps;

  // r_k is never zero while in FEED, so this subtraction cannot underflow there.
  assign w_k_last = c_CNT_W'(r_k) - c_CNT_W'(1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_k     = r_k;
    w_nxt_row   = r_row;
    w_nxt_col   = r_col;
    w_accept    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          if (k_steps_i != '0) begin
            w_nxt_k     = k_steps_i;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_CLEAR;
          end else begin
            w_nxt_state = ST_DONE;
          end
        end
      end

      ST_CLEAR: begin
        w_nxt_cnt   = '0;
        w_nxt_state = ST_FEED;
      end

      ST_FEED: begin
        if (r_cnt == w_k_last) begin
          w_nxt_cnt   = '0;
          w_nxt_state = ST_DRAIN;
        end else begin
          w_nxt_cnt = r_cnt + c_CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          w_nxt_cnt   = '0;
          w_nxt_state = ST_OUTPUT;
        end else begin
          w_nxt_cnt = r_cnt + c_CNT_W'(1);
        end
      end

      ST_OUTPUT: begin
        // Row-major walk; indices wrap to 0 on the final beat so that they
        // read 0 again whenever no result is being offered.
        if (r_res_valid && res_ready_i) begin
          if (r_col == c_COL_LAST) begin
            w_nxt_col = '0;
            if (r_row == c_ROW_LAST) begin
              w_nxt_row   = '0;
              w_nxt_state = ST_DONE;
            end else begin
              w_nxt_row = r_row + c_ROW_W'(1);
            end
          end else begin
            w_nxt_col = r_col + c_COL_W'(1);
          end
        end
      end

      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from the next state so
  // they line up with the state they describe without any output-side logic.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_clear <= 1'b0;
      r_feed_en   <= 1'b0;
      r_feed_addr <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_k         <= w_nxt_k;
      r_row       <= w_nxt_row;
      r_col       <= w_nxt_col;
      r_busy      <= (w_nxt_state != ST_IDLE);
      r_done      <= (w_nxt_state == ST_DONE);
      r_acc_clear <= (w_nxt_state == ST_CLEAR);
      r_feed_en   <= (w_nxt_state == ST_FEED);
      r_feed_addr <= (w_nxt_state == ST_FEED) ? ADDR_WIDTH'(w_nxt_cnt) : '0;
      r_res_valid <= (w_nxt_state == ST_OUTPUT);
    end
  end

  // --------------------------------------------------------------------------
  // Skewed enables: tap t drives column t and row t.
  // --------------------------------------------------------------------------
  sta_skew_line #(
    .TAPS       (c_TAPS),
    .PE_LATENCY (PE_LATENCY)
  ) u_skew (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .in_i     (r_feed_en),
    .taps_o   (w_taps)
  );

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign acc_clear_o = r_acc_clear;
  assign feed_en_o   = r_feed_en;
  assign feed_addr_o = r_feed_addr;
  assign data_en_o   = w_taps[N-1:0];
  assign weight_en_o = w_taps[M-1:0];
  assign res_valid_o = r_res_valid;
  assign res_row_o   = r_row;
  assign res_col_o   = r_col;

`ifdef STA_TILE_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else if (r_busy) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles_o = r_perf;
`endif

endmodule : sta_tile_ctrl
`default_nettype wire

// File: tb/tb_sta_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sta_tile_ctrl
//  Purpose  : Self-checking bench for sta_tile_ctrl. A job-level model derives
//             every output from the job's start time, K and the handshakes
//             seen so far; directed literal checks pin the model.
//  Options  : STA_TILE_CTRL_PERF_EN - also checks perf_cycles_o.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sta_tile_ctrl;

  localparam int N  = 2;
  localparam int M  = 2;
  localparam int L  = 4;
  localparam int KW = 8;
  localparam int AW = 10;
  localparam int D  = (M + N - 1) * L;   // 12 drain cycles

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          start_i;
  logic [KW-1:0] k_steps_i;
  logic          busy_o, done_o, acc_clear_o, feed_en_o, res_valid_o;
  logic [AW-1:0] feed_addr_o;
  logic [N-1:0]  data_en_o;
  logic [M-1:0]  weight_en_o;
  logic          res_ready_i;
  logic [0:0]    res_row_o;
  logic [0:0]    res_col_o;
`ifdef STA_TILE_CTRL_PERF_EN
  logic [31:0]   perf_cycles_o;
`endif

  sta_tile_ctrl #(
    .N(N), .M(M), .PE_LATENCY(L), .K_WIDTH(KW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .k_steps_i   (k_steps_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .acc_clear_o (acc_clear_o),
    .feed_en_o   (feed_en_o),
    .feed_addr_o (feed_addr_o),
    .data_en_o   (data_en_o),
    .weight_en_o (weight_en_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_row_o   (res_row_o),
    .res_col_o   (res_col_o)
`ifdef STA_TILE_CTRL_PERF_EN
    ,
    .perf_cycles_o (perf_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_hs    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Job-level model and per-cycle compare (outputs sampled on falling edge)
  // --------------------------------------------------------------------------
  bit m_active = 0, m_zero = 0, m_done_pend = 0;
  int m_t = 0, m_k = 0, m_beats = 0, m_perf = 0;

  always @(negedge clk_i) begin
    logic         e_busy, e_done, e_clear, e_feed, e_valid, accept;
    logic [31:0]  e_addr, e_row, e_col;
    logic [N-1:0] e_den;
    logic [M-1:0] e_wen;
    int tt;
    e_busy = 0; e_done = 0; e_clear = 0; e_feed = 0; e_valid = 0;
    e_addr = 0; e_row = 0; e_col = 0; e_den = '0; e_wen = '0;

    if (reset_ni && m_active) begin
      e_busy = 1;
      if (m_zero) begin
        e_done = 1;
      end else begin
        e_clear = (m_t == 1);
        e_feed  = (m_t >= 2) && (m_t <= m_k + 1);
        e_addr  = e_feed ? 32'(m_t - 2) : 32'd0;
        for (int n = 0; n < N; n++) begin
          tt = m_t - n * L;
          e_den[n] = (tt >= 2) && (tt <= m_k + 1);
        end
        for (int m = 0; m < M; m++) begin
          tt = m_t - m * L;
          e_wen[m] = (tt >= 2) && (tt <= m_k + 1);
        end
        e_valid = (m_t >= m_k + 2 + D) && !m_done_pend;
        if (e_valid) begin
          e_row = 32'(m_beats / N);
          e_col = 32'(m_beats % N);
        end
        e_done = m_done_pend;
      end
    end

    check("busy", busy_o, e_busy);
    check("done", done_o, e_done);
    check("acc_clear", acc_clear_o, e_clear);
    check("feed_en", feed_en_o, e_feed);
    check("feed_addr", feed_addr_o, e_addr);
    check("data_en", data_en_o, e_den);
    check("weight_en", weight_en_o, e_wen);
    check("res_valid", res_valid_o, e_valid);
    check("res_row", res_row_o, e_row);
    check("res_col", res_col_o, e_col);
`ifdef STA_TILE_CTRL_PERF_EN
    check("perf_cycles", perf_cycles_o, m_perf);
`endif

    if (!reset_ni) begin
      m_active = 0; m_perf = 0;
    end else begin
      if (done_o) n_done++;
      if (res_valid_o && res_ready_i) n_hs++;
      accept = !m_active && start_i;
      if (accept) m_perf = 0;
      else if (e_busy) m_perf++;
      if (m_active) begin
        if (e_done) m_active = 0;
        else begin
          if (e_valid && res_ready_i) begin
            m_beats++;
            if (m_beats == M * N) m_done_pend = 1;
          end
          m_t++;
        end
      end else if (start_i) begin
        m_active = 1; m_t = 1; m_k = int'(k_steps_i);
        m_zero = (k_steps_i == '0); m_beats = 0; m_done_pend = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  int s = 0;   // job-relative cycle j is the cycle where cyc == s + j

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_start(input int k);
    start_i = 1'b1; k_steps_i = KW'(k);
    tick();
    start_i = 1'b0;
    s = cyc - 1;
  endtask

  task automatic at_cyc(input int j);
    while (cyc < s + j) tick();
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int d0, h0;
    reset_ni = 1'b0; start_i = 1'b0; k_steps_i = '0; res_ready_i = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_addr", feed_addr_o, 0);
    reset_ni = 1'b1;
    repeat (2) tick();

    // Basic job, K=3, ready high
    do_start(3);
    at_cyc(1);  check("b_clear_c1", acc_clear_o, 1);
    at_cyc(2);  check("b_addr_c2", feed_addr_o, 0); check("b_feed_c2", feed_en_o, 1);
    at_cyc(3);  check("b_addr_c3", feed_addr_o, 1);
    at_cyc(4);  check("b_addr_c4", feed_addr_o, 2);
    at_cyc(5);  check("b_feed_c5", feed_en_o, 0);
    at_cyc(6);  check("b_den_c6", data_en_o, 2'b10); check("b_wen_c6", weight_en_o, 2'b10);
    at_cyc(8);  check("b_den_c8", data_en_o, 2'b10);
    at_cyc(9);  check("b_den_c9", data_en_o, 2'b00);
    at_cyc(16); check("b_valid_c16", res_valid_o, 0);
    at_cyc(17); check("b_valid_c17", res_valid_o, 1);
                check("b_rc_c17", {res_row_o, res_col_o}, 2'b00);
    at_cyc(18); check("b_rc_c18", {res_row_o, res_col_o}, 2'b01);
    at_cyc(19); check("b_rc_c19", {res_row_o, res_col_o}, 2'b10);
    at_cyc(20); check("b_rc_c20", {res_row_o, res_col_o}, 2'b11);
    at_cyc(21); check("b_done_c21", done_o, 1); check("b_valid_c21", res_valid_o, 0);
`ifdef STA_TILE_CTRL_PERF_EN
    at_cyc(22); check("perf_after_done", perf_cycles_o, 21);
    at_cyc(30); check("perf_held", perf_cycles_o, 21);
`else
    at_cyc(24);
`endif
    check("b_idle", busy_o, 0);

    // Backpressure, K=2, ready toggling each cycle
    d0 = n_done; h0 = n_hs;
    do_start(2);
    for (int i = 0; i < 100 && n_done == d0; i++) begin
      res_ready_i = ~res_ready_i;
      tick();
    end
    res_ready_i = 1'b1;
    check("bp_done_count", n_done - d0, 1);
    check("bp_handshakes", n_hs - h0, 4);
    repeat (3) tick();

    // Zero-length job
    d0 = n_done;
    do_start(0);
    at_cyc(1); check("z_done_c1", done_o, 1); check("z_busy_c1", busy_o, 1);
               check("z_clear_c1", acc_clear_o, 0);
    at_cyc(2); check("z_done_c2", done_o, 0); check("z_busy_c2", busy_o, 0);
    check("z_done_count", n_done - d0, 1);
    repeat (2) tick();

    // Start while busy: pulses during FEED and during DONE are ignored
    d0 = n_done;
    do_start(3);
    at_cyc(3);  start_i = 1'b1; k_steps_i = 8'd5; tick(); start_i = 1'b0;
    at_cyc(21); check("sb_done_c21", done_o, 1);
                start_i = 1'b1; k_steps_i = 8'd2; tick(); start_i = 1'b0;
    at_cyc(23); check("sb_idle_c23", busy_o, 0);
    at_cyc(40); check("sb_done_count", n_done - d0, 1);
                check("sb_still_idle", busy_o, 0);

    // Reset during DRAIN
    d0 = n_done;
    do_start(2);
    at_cyc(6);  check("r_den_c6", data_en_o, 2'b10); check("r_busy_c6", busy_o, 1);
    #1 reset_ni = 1'b0;
    #1;
    check("r_async_busy", busy_o, 0);
    check("r_async_den", data_en_o, 0);
    check("r_async_wen", weight_en_o, 0);
    check("r_async_rc", {res_row_o, res_col_o}, 0);
    tick(); #1 reset_ni = 1'b1;
    repeat (25) tick();
    check("r_no_done", n_done - d0, 0);
    check("r_idle", busy_o, 0);
    d0 = n_done;
    do_start(1);
    at_cyc(2);  check("r_k1_addr_c2", feed_addr_o, 0); check("r_k1_feed_c2", feed_en_o, 1);
    at_cyc(15); check("r_k1_valid_c15", res_valid_o, 1);
    at_cyc(19); check("r_k1_done_c19", done_o, 1);
    at_cyc(21); check("r_k1_done_count", n_done - d0, 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sta_tile_ctrl
`default_nettype wire
